// File: rtl/apb_irq_ctrl_if.sv
// APB slave bus bundle for the interrupt controller.
// The master modport is the bus side (testbench or interconnect); the slave
// modport is the controller side.
interface apb_irq_ctrl_if #(
  parameter int APB_ADDR_WIDTH = 12
);
  logic [APB_ADDR_WIDTH-1:0] PADDR;
  logic [31:0]               PWDATA;
  logic                      PWRITE;
  logic                      PSEL;
  logic                      PENABLE;
  logic [31:0]               PRDATA;
  logic                      PREADY;
  logic                      PSLVERR;

  modport master (
    output PADDR, PWDATA, PWRITE, PSEL, PENABLE,
    input  PRDATA, PREADY, PSLVERR
  );

  modport slave (
    input  PADDR, PWDATA, PWRITE, PSEL, PENABLE,
    output PRDATA, PREADY, PSLVERR
  );
endinterface

// File: rtl/apb_irq_ctrl.sv
// APB-programmable interrupt controller.
// Rising edges on level sources latch into PENDING. Sources enabled by MASK
// are offered one at a time to the core over a req/ack handshake. Among the
// enabled pending sources, the lowest index has the highest priority.
module apb_irq_ctrl #(
  parameter int APB_ADDR_WIDTH = 12,
  parameter int NUM_IRQ        = 8
) (
  input  logic               HCLK,
  input  logic               HRESETn,
  apb_irq_ctrl_if.slave      apb,
  input  logic [NUM_IRQ-1:0] irq_i,
  output logic               core_irq_req_o,
  output logic [4:0]         core_irq_id_o,
  input  logic               core_irq_ack_i
);

  typedef enum logic {IDLE = 1'b0, REQ = 1'b1} state_t;

  localparam logic [1:0] SEL_MASK    = 2'b00;
  localparam logic [1:0] SEL_PENDING = 2'b01;
  localparam logic [1:0] SEL_SET     = 2'b10;
  localparam logic [1:0] SEL_STATUS  = 2'b11;

  state_t               state_q, state_d;
  logic [NUM_IRQ-1:0]   mask_q, mask_d;
  logic [NUM_IRQ-1:0]   pending_q, pending_d;
  logic [NUM_IRQ-1:0]   irq_prev_q;
  logic                 req_q, req_d;
  logic [4:0]           id_q, id_d;

  logic [APB_ADDR_WIDTH-1:0] paddr;
  logic [1:0]                sel;
  logic                      wr_en;
  logic                      rd_en;
  logic [NUM_IRQ-1:0]        wdata;
  logic [NUM_IRQ-1:0]        rise;
  logic [NUM_IRQ-1:0]        w1c;
  logic [NUM_IRQ-1:0]        w1s;
  logic [NUM_IRQ-1:0]        ack_clr;
  logic [NUM_IRQ-1:0]        masked;
  logic [4:0]                lowest_id;
  logic [31:0]               rdata;
  logic                      unused_bits;

  assign paddr = apb.PADDR;
  assign sel   = paddr[3:2];
  assign wr_en = apb.PSEL & apb.PENABLE & apb.PWRITE;
  assign rd_en = apb.PSEL & apb.PENABLE & ~apb.PWRITE;
  assign wdata = apb.PWDATA[NUM_IRQ-1:0];

  // Upper address bits and write-data bits beyond NUM_IRQ are not decoded.
  assign unused_bits = ^{paddr, apb.PWDATA};

  // A source that is already high when reset is released reads as a rise,
  // because irq_prev resets to 0.
  assign rise   = irq_i & ~irq_prev_q;
  assign w1c    = (wr_en && sel == SEL_PENDING) ? wdata : '0;
  assign w1s    = (wr_en && sel == SEL_SET)     ? wdata : '0;
  assign masked = pending_q & mask_q;

  // Acknowledge clears only the bit that is being served, and only in REQ.
  generate
    for (genvar gi = 0; gi < NUM_IRQ; gi++) begin : g_ack_clr
      assign ack_clr[gi] = (state_q == REQ) && core_irq_ack_i &&
                           (id_q == 5'(gi));
    end
  endgenerate

  // Set sources (rise, SET) override the clear sources on the same bit.
  always_comb begin
    pending_d = (pending_q & ~w1c & ~ack_clr) | rise | w1s;
    mask_d    = mask_q;
    if (wr_en && sel == SEL_MASK) begin
      mask_d = wdata;
    end
  end

  // Fixed-priority encoder: the lowest set index wins.
  always_comb begin
    lowest_id = 5'd0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (masked[i]) begin
        lowest_id = 5'(i);
      end
    end
  end

  // Arbiter next state. The request is never withdrawn or pre-empted, and
  // it ends only on ack. Leaving through IDLE creates the one-cycle gap.
  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    id_d    = id_q;
    case (state_q)
      IDLE: begin
        if (|masked) begin
          state_d = REQ;
          req_d   = 1'b1;
          id_d    = lowest_id;
        end
      end
      REQ: begin
        if (core_irq_ack_i) begin
          state_d = IDLE;
          req_d   = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        req_d   = 1'b0;
      end
    endcase
  end

  // State, register file and edge-detect history.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q    <= IDLE;
      mask_q     <= '0;
      pending_q  <= '0;
      irq_prev_q <= '0;
      req_q      <= 1'b0;
      id_q       <= 5'd0;
    end else begin
      state_q    <= state_d;
      mask_q     <= mask_d;
      pending_q  <= pending_d;
      irq_prev_q <= irq_i;
      req_q      <= req_d;
      id_q       <= id_d;
    end
  end

  // Read mux. It is combinational from registered state and returns 0
  // outside a read access phase.
  always_comb begin
    rdata = 32'd0;
    if (rd_en) begin
      case (sel)
        SEL_MASK:    rdata = 32'(mask_q);
        SEL_PENDING: rdata = 32'(pending_q);
        SEL_SET:     rdata = 32'd0;
        SEL_STATUS:  rdata = {19'd0, id_q, 7'd0, req_q};
        default:     rdata = 32'd0;
      endcase
    end
  end

  assign apb.PRDATA  = rdata;
  assign apb.PREADY  = 1'b1;
  assign apb.PSLVERR = 1'b0;

  assign core_irq_req_o = req_q;
  assign core_irq_id_o  = id_q;

endmodule

// File: tb/tb_apb_irq_ctrl.sv
// Directed and randomized bench for apb_irq_ctrl. A behavioural reference
// model runs alongside the DUT.
module tb_apb_irq_ctrl;
  localparam int AW = 12;
  localparam int N  = 8;

  logic         HCLK = 1'b0;
  logic         HRESETn = 1'b0;
  logic [N-1:0] irq_i = '0;
  logic         core_irq_ack = 1'b0;
  logic         core_irq_req;
  logic [4:0]   core_irq_id;

  int checks = 0;
  int errors = 0;
  bit chk_on = 1'b0;

  apb_irq_ctrl_if #(.APB_ADDR_WIDTH(AW)) bus ();

  apb_irq_ctrl #(.APB_ADDR_WIDTH(AW), .NUM_IRQ(N)) dut (
    .HCLK           (HCLK),
    .HRESETn        (HRESETn),
    .apb            (bus),
    .irq_i          (irq_i),
    .core_irq_req_o (core_irq_req),
    .core_irq_id_o  (core_irq_id),
    .core_irq_ack_i (core_irq_ack)
  );

  always #5 HCLK = ~HCLK;

  // ---------------- reference model ----------------
  bit m_mask [N];
  bit m_pend [N];
  bit m_prev [N];
  bit m_req;
  int m_id;

  always @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      for (int i = 0; i < N; i++) begin
        m_mask[i] = 0; m_pend[i] = 0; m_prev[i] = 0;
      end
      m_req = 0;
      m_id  = 0;
    end else begin
      bit wr;
      int s;
      bit np [N];
      int pick;
      wr = bus.PSEL && bus.PENABLE && bus.PWRITE;
      s  = int'(bus.PADDR[3:2]);
      for (int i = 0; i < N; i++) begin
        bit set_src, clr_src;
        set_src = (irq_i[i] && !m_prev[i]) || (wr && s == 2 && bus.PWDATA[i]);
        clr_src = (wr && s == 1 && bus.PWDATA[i]) ||
                  (m_req && core_irq_ack && m_id == i);
        np[i] = set_src || (m_pend[i] && !clr_src);
      end
      if (m_req) begin
        if (core_irq_ack) m_req = 0;
      end else begin
        pick = -1;
        for (int i = N - 1; i >= 0; i--) if (m_pend[i] && m_mask[i]) pick = i;
        if (pick >= 0) begin
          m_req = 1;
          m_id  = pick;
        end
      end
      if (wr && s == 0) for (int i = 0; i < N; i++) m_mask[i] = bus.PWDATA[i];
      for (int i = 0; i < N; i++) begin
        m_prev[i] = irq_i[i];
        m_pend[i] = np[i];
      end
    end
  end

  function automatic logic [31:0] model_read(input logic [1:0] s);
    logic [31:0] r;
    r = 32'd0;
    case (s)
      2'd0: for (int i = 0; i < N; i++) r[i] = m_mask[i];
      2'd1: for (int i = 0; i < N; i++) r[i] = m_pend[i];
      2'd3: begin r[0] = m_req; r[12:8] = 5'(m_id); end
      default: r = 32'd0;
    endcase
    return r;
  endfunction

  // ---------------- checking helpers ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Continuous check of the core-side outputs and of idle PRDATA against the model.
  always begin
    @(negedge HCLK);
    #2;
    if (chk_on) begin
      chk("mdl_req", 32'(core_irq_req), 32'(m_req));
      chk("mdl_id", 32'(core_irq_id), 32'(m_id));
      if (!(bus.PSEL && bus.PENABLE && !bus.PWRITE))
        chk("prdata_idle", bus.PRDATA, 32'd0);
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) @(negedge HCLK);
  endtask

  task automatic apb_write(input logic [AW-1:0] a, input logic [31:0] d);
    bus.PSEL = 1'b1; bus.PWRITE = 1'b1; bus.PADDR = a; bus.PWDATA = d; bus.PENABLE = 1'b0;
    @(negedge HCLK);
    bus.PENABLE = 1'b1;
    @(negedge HCLK);
    bus.PSEL = 1'b0; bus.PENABLE = 1'b0; bus.PWRITE = 1'b0;
    $display("APB WR addr=0x%03h data=0x%08h", a, d);
  endtask

  task automatic apb_read(input logic [AW-1:0] a, output logic [31:0] d);
    bus.PSEL = 1'b1; bus.PWRITE = 1'b0; bus.PADDR = a; bus.PENABLE = 1'b0;
    @(negedge HCLK);
    bus.PENABLE = 1'b1;
    #1 d = bus.PRDATA;
    @(negedge HCLK);
    bus.PSEL = 1'b0; bus.PENABLE = 1'b0;
    $display("APB RD addr=0x%03h data=0x%08h", a, d);
  endtask

  task automatic ack_pulse();
    core_irq_ack = 1'b1;
    tick();
    core_irq_ack = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] rd;
    int phase;
    bus.PSEL = 1'b0; bus.PENABLE = 1'b0; bus.PWRITE = 1'b0;
    bus.PADDR = '0; bus.PWDATA = '0;
    tick(2);
    chk_on = 1'b1;
    chk("rst_req", 32'(core_irq_req), 32'd0);
    chk("rst_id", 32'(core_irq_id), 32'd0);
    HRESETn = 1'b1;
    apb_read(12'h000, rd); chk("rst_mask", rd, 32'd0);
    apb_read(12'h004, rd); chk("rst_pend", rd, 32'd0);

    // Single pulse on source 0.
    apb_write(12'h000, 32'h1);
    irq_i = 8'h01; tick();
    irq_i = 8'h00; tick();
    chk("t1_req", 32'(core_irq_req), 32'd1);
    chk("t1_id", 32'(core_irq_id), 32'd0);
    apb_read(12'h004, rd); chk("t1_pend", rd, 32'h1);
    ack_pulse();
    chk("t1_req_ack", 32'(core_irq_req), 32'd0);
    apb_read(12'h004, rd); chk("t1_pend_clr", rd, 32'h0);

    // Masked source becomes pending but raises no request until unmasked.
    apb_write(12'h000, 32'h0);
    irq_i = 8'h08; tick(2);
    apb_read(12'h004, rd); chk("t2_pend", rd, 32'h08);
    chk("t2_req_masked", 32'(core_irq_req), 32'd0);
    apb_write(12'h000, 32'h08);
    tick();
    chk("t2_req", 32'(core_irq_req), 32'd1);
    chk("t2_id", 32'(core_irq_id), 32'd3);
    ack_pulse();
    irq_i = 8'h00; tick();

    // Simultaneous rises on sources 2 and 5.
    apb_write(12'h000, 32'hFF);
    irq_i = 8'h24; tick();
    irq_i = 8'h00; tick();
    chk("t3_id_first", 32'(core_irq_id), 32'd2);
    chk("t3_req_first", 32'(core_irq_req), 32'd1);
    ack_pulse();
    chk("t3_gap", 32'(core_irq_req), 32'd0);
    tick();
    chk("t3_req_second", 32'(core_irq_req), 32'd1);
    chk("t3_id_second", 32'(core_irq_id), 32'd5);
    ack_pulse();
    chk("t3_req_done", 32'(core_irq_req), 32'd0);
    apb_read(12'h004, rd); chk("t3_pend", rd, 32'h0);

    // A new rise on the served source coincides with its ack.
    irq_i = 8'h10; tick();
    irq_i = 8'h00; tick();
    chk("t4_id", 32'(core_irq_id), 32'd4);
    core_irq_ack = 1'b1; irq_i = 8'h10; tick();
    core_irq_ack = 1'b0; irq_i = 8'h00;
    chk("t4_gap", 32'(core_irq_req), 32'd0);
    tick();
    chk("t4_req_again", 32'(core_irq_req), 32'd1);
    chk("t4_id_again", 32'(core_irq_id), 32'd4);
    apb_read(12'h004, rd); chk("t4_pend", rd, 32'h10);
    ack_pulse();

    // SET then W1C on bit 7; STATUS while serving id 7.
    apb_write(12'h008, 32'h80);
    apb_read(12'h004, rd); chk("t5_pend_set", rd, 32'h80);
    apb_write(12'h004, 32'h80);
    apb_read(12'h004, rd); chk("t5_pend_clr", rd, 32'h0);
    apb_read(12'h008, rd); chk("t5_set_reads0", rd, 32'h0);
    apb_read(12'h00C, rd); chk("t5_status", rd, 32'h0000_0701);

    // Asynchronous reset during REQ with source 1 held high across release.
    irq_i = 8'h02;
    #3 HRESETn = 1'b0;
    #1 chk("t6_req_rst", 32'(core_irq_req), 32'd0);
    chk("t6_id_rst", 32'(core_irq_id), 32'd0);
    tick();
    apb_read(12'h000, rd); chk("t6_mask_rst", rd, 32'h0);
    apb_read(12'h004, rd); chk("t6_pend_rst", rd, 32'h0);
    HRESETn = 1'b1;
    tick();
    apb_read(12'h004, rd); chk("t6_pend_rise", rd, 32'h2);
    irq_i = 8'h00;

    // Randomized traffic checked against the model.
    phase = 0;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      @(negedge HCLK);
      irq_i = irq_i ^ 8'($urandom & $urandom & $urandom);
      core_irq_ack = ($urandom_range(0, 3) == 0);
      if (phase == 1) begin
        bus.PENABLE = 1'b1;
        phase = 2;
        if (!bus.PWRITE) begin
          #1;
          chk($sformatf("rnd_rd_sel%0d", bus.PADDR[3:2]), bus.PRDATA, model_read(bus.PADDR[3:2]));
        end
      end else begin
        bus.PSEL = 1'b0; bus.PENABLE = 1'b0; bus.PWRITE = 1'b0;
        phase = 0;
        if ($urandom_range(0, 1) == 1) begin
          bus.PSEL = 1'b1;
          bus.PWRITE = 1'($urandom_range(0, 1));
          bus.PADDR = AW'($urandom);
          bus.PWDATA = $urandom;
          phase = 1;
        end
      end
    end
    bus.PSEL = 1'b0; bus.PENABLE = 1'b0; bus.PWRITE = 1'b0;
    core_irq_ack = 1'b0;
    tick(2);
    chk_on = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/apb_irq_ctrl.md
Name: apb_irq_ctrl

Overview:
- APB-programmable interrupt controller downstream of the timer and other APB peripherals.
- Edge-detects level interrupt lines (e.g. timer overflow/compare irq bits), latches them as pending, masks them, and arbitrates by fixed priority.
- Presents one request at a time to the core with a req/ack handshake.
- Sits on the APB bus beside the timer; its output drives the core interrupt input.

Parameters:
APB_ADDR_WIDTH, 12, APB address width (4KB slave)
NUM_IRQ, 8, number of interrupt inputs (1..32)

Ports:
HCLK  input  1  clock
HRESETn  input  1  reset, asynchronous, active-low
PADDR  input  APB_ADDR_WIDTH  APB address; PADDR[3:2] selects register
PWDATA  input  32  APB write data
PWRITE  input  1  APB write strobe
PSEL  input  1  APB select
PENABLE  input  1  APB enable
PRDATA  output  32  APB read data
PREADY  output  1  tied 1
PSLVERR  output  1  tied 0
irq_i  input  NUM_IRQ  level interrupt sources; index 0 is highest priority
core_irq_req_o  output  1  interrupt request to core
core_irq_id_o  output  5  index of the requested interrupt
core_irq_ack_i  input  1  core acknowledge, single-cycle pulse

Behaviour:
- Clock and reset: one clock, HCLK. Reset HRESETn is asynchronous, active-low.
- Reset values: mask, pending, irq_prev, state=IDLE, core_irq_req_o=0, core_irq_id_o=0, PRDATA=0.
- Register map (PADDR[3:2]):
  - 00 MASK: RW; bit=1 enables that source.
  - 01 PENDING: read returns pending; write-1-to-clear.
  - 10 SET: write-1-to-set pending; reads 0.
  - 11 STATUS: read only; bit0 = core_irq_req_o, bits[12:8] = core_irq_id_o, others 0.
- Register bits at index >= NUM_IRQ read 0; writes to them are ignored.
- APB write: happens when PSEL & PENABLE & PWRITE.
- APB read: PRDATA is driven only when PSEL & PENABLE & !PWRITE, otherwise 0. Read is combinational from registered state.
- Edge detect: irq_prev <= irq_i every cycle.
  - rise = irq_i & ~irq_prev.
  - Pending bit sets at the clock edge where the rise is sampled.
  - A source already high at reset release counts as a rise on the first edge.
  - A held-high level does not re-trigger.
- Pending next value = (pending & ~w1c & ~ack_clr) | rise | w1s. Set always beats clear on the same bit in the same cycle (rise or SET vs PENDING-W1C or ack).
- Arbiter / FSM, two states:
  - IDLE: if (pending & mask) != 0, latch the lowest set index into core_irq_id_o, assert core_irq_req_o, go to REQ. Latency: irq_i sampled high at edge k → pending at k → core_irq_req_o high after edge k+1.
  - REQ: core_irq_req_o and core_irq_id_o are held stable. On core_irq_ack_i: clear pending[core_irq_id_o], deassert req, go to IDLE.
  - After ack, req stays low at least one cycle before the next request.
  - Ack in IDLE is ignored.
- Changes during REQ:
  - Clearing MASK or W1C of the active pending bit does not withdraw the request.
  - Ack still clears the bit, which is harmless if already cleared.
  - A higher-priority arrival does not pre-empt; it is served next.
- No counting of repeated events: a second rise while pending is still set is merged.

Test Plan:
- Reset, MASK=0x1, pulse irq_i[0] for one cycle → PENDING reads 0x1; core_irq_req_o=1, id=0 two cycles after the pulse; ack → req=0 next cycle, PENDING=0.
- MASK=0x00, rise on irq_i[3] → PENDING=0x08, req stays 0; then write MASK=0x08 → req=1, id=3 two cycles later.
- MASK=0xFF, rises on bits 2 and 5 in the same cycle → id=2 first; ack → req low one cycle, then id=5; second ack → PENDING=0.
- In REQ with id=4, a new rise on irq_i[4] coincides with the ack → PENDING[4] stays 1, a new request for id=4 follows after the one-cycle gap.
- Write SET=0x80 and W1C PENDING=0x80 in consecutive cycles → bit 7 reads 1 then 0. Read STATUS while in REQ with id=7 → 0x0000_0701.
- Assert HRESETn low during REQ → core_irq_req_o=0, MASK/PENDING=0 immediately. irq_i[1] held high across release → PENDING=0x2 after the first edge.
